code_counter_encoder: RTL and testbench
=======================================

Name: code_counter_encoder

Overview:
- Parametrised up/down counter whose count is presented on a registered output in a code chosen at run time: binary, Gray, one-hot or thermometer.
- Successor to the team's fixed 3-bit combinational Gray/one-hot encoders. Adds generic width, a programmable wrap point, load, direction, run-time mode select and terminal-count flagging.
- Used as a sequencer / position tracker feeding decoders and LED/segment drivers.

Parameters:
- WIDTH, 3, count width in bits (2..8).
- MAX_COUNT, 2**WIDTH-1, highest count value before wrap (1..2**WIDTH-1).
- OUT_W, 2**WIDTH, output code width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value to load.
- mode  input  2  output code: 00 binary, 01 Gray, 10 one-hot, 11 thermometer.
- count  output  WIDTH  raw binary count.
- code_out  output  OUT_W  encoded count, zero-extended to OUT_W.
- tc  output  1  terminal-count pulse on wrap.

Behaviour:
- Reset (asynchronous, takes effect immediately while rst=1):
  - count=0, tc=0.
  - code_out=encode(0, mode), sampled at each edge while in reset. Mode 00/01 gives all zeros; mode 10 gives bit0=1; mode 11 gives all zeros.
- Next-count priority, evaluated each rising edge:
  1. load=1: count <= min(load_val, MAX_COUNT). Values above MAX_COUNT are clamped. en and up are ignored.
  2. en=1, up=1: count <= (count==MAX_COUNT) ? 0 : count+1.
  3. en=1, up=0: count <= (count==0) ? MAX_COUNT : count-1.
  4. Otherwise: count holds.
- tc: registered. It is 1 for exactly one cycle after an edge where a wrap occurred, i.e. MAX_COUNT->0 going up or 0->MAX_COUNT going down. A load never sets tc, even if the loaded value equals a wrap endpoint.
- code_out: registered as encode(next_count, mode) at the same edge that updates count, so code_out always matches count with no extra latency. A mode change alone, with count holding, re-encodes code_out at the next edge.
- Encodings for value k:
  - binary: k.
  - Gray: k ^ (k>>1).
  - one-hot: bit k set, all others clear.
  - thermometer: bits [k-1:0] set, so k=0 gives all zeros.
  - Upper bits beyond the code width are always 0.
- Gray property: in mode 01 with MAX_COUNT=2**WIDTH-1, successive outputs while en=1 differ in exactly one bit, including across the wrap. With a non-power-of-two MAX_COUNT the wrap step is exempt.
- Input handling: all inputs are sampled synchronously, with no combinational path from inputs to outputs. An rst assertion mid-count returns all outputs to reset values within the same cycle, asynchronously.
- Undefined mode values cannot occur, since all four codes are defined.

Decomposition:
- Shared package code_pkg holds:
  - mode constants MODE_BIN=2'b00, MODE_GRAY=2'b01, MODE_ONEHOT=2'b10, MODE_THERM=2'b11;
  - the helper computing OUT_W from WIDTH.
- One combinational sub-module, code_encoder (parameters WIDTH, OUT_W; inputs value, mode; output code). It is reusable by the existing encoder users.
- The top level holds the counter, wrap/clamp logic, tc, and the output registers.

Test Plan:
- Reset with WIDTH=3, mode=10: assert rst mid-count (count=5) -> count=0, code_out=8'b0000_0001, tc=0, without waiting for a clock edge.
- Gray up-count, mode=01, en=1, up=1, 9 edges from 0 -> code_out sequence 000,001,011,010,110,111,101,100,000 (zero-extended to 8 bits); tc=1 only in the cycle after 7->0; every step flips exactly 1 bit.
- Down wrap with MAX_COUNT=5, mode=00, up=0 from count=1 -> 1,0,5,4; tc high one cycle after 0->5.
- Load priority and clamp with MAX_COUNT=5: load=1, en=1, load_val=7 -> count=5, tc=0; next edge with load=0, up=1 -> count=0, tc=1.
- Mode switch with count held at 3 (en=0): mode 00->11 -> next edge code_out=8'b0000_0111; mode 10 -> 8'b0000_1000; count is unchanged throughout.
- Hold: en=0, load=0 for 4 edges at count=6 -> count, code_out and tc (0) are stable.

Source files
------------

// File: rtl/code_pkg.sv
// Shared definitions for the code encoder family: output-code selectors and
// the output-width helper.
package code_pkg;

    localparam logic [1:0] MODE_BIN    = 2'b00;
    localparam logic [1:0] MODE_GRAY   = 2'b01;
    localparam logic [1:0] MODE_ONEHOT = 2'b10;
    localparam logic [1:0] MODE_THERM  = 2'b11;

    // One-hot and thermometer codes need one bit per representable value.
    function automatic int code_width(input int width);
        return 1 << width;
    endfunction

endpackage

// File: rtl/code_encoder.sv
// Combinational value encoder: binary, Gray, one-hot or thermometer,
// zero-extended to OUT_W bits.
module code_encoder
    import code_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int OUT_W = code_width(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] code
);

    logic [WIDTH-1:0] gray;
    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] therm;

    assign gray = value ^ (value >> 1);

    for (genvar i = 0; i < OUT_W; i++) begin : g_bit
        assign onehot[i] = (int'(value) == i);
        assign therm[i]  = (int'(value) > i);
    end

    always_comb begin
        code = '0;
        case (mode)
            MODE_BIN:    code = OUT_W'(value);
            MODE_GRAY:   code = OUT_W'(gray);
            MODE_ONEHOT: code = onehot;
            default:     code = therm;
        endcase
    end

endmodule

// File: rtl/code_counter_encoder.sv
// Up/down wrap counter with load/clamp, terminal-count pulse and a run-time
// selectable output code.
module code_counter_encoder
    import code_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int MAX_COUNT = (1 << WIDTH) - 1,
    parameter int OUT_W     = code_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic [OUT_W-1:0] code_out,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] count_d, count_q;
    logic             tc_d, tc_q;
    logic [1:0]       mode_d, mode_q;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        mode_d  = mode;
        if (load) begin
            count_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            if (up) begin
                if (count_q == MAX_V) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX_V;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    // Mode keeps sampling through reset, so code_out shows encode(0, mode)
    // the instant rst rises and at every edge while it is held.
    always_ff @(posedge clk) begin
        mode_q <= mode_d;
    end

    // code_out is decoded purely from registered count and mode: it tracks
    // count with no extra latency and has no path from the data inputs.
    code_encoder #(.WIDTH(WIDTH), .OUT_W(OUT_W)) u_enc (
        .value (count_q),
        .mode  (mode_q),
        .code  (code_out)
    );

    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_code_counter_encoder.sv
// Scoreboard bench: two counters (full-range and MAX_COUNT=5) share stimulus;
// an arithmetic reference model queues expectations, a monitor checks them.
module tb_code_counter_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, up = 1'b0, load = 1'b0;
    logic [2:0] load_val = '0;
    logic [1:0] mode = 2'b00;
    logic [2:0] count7, count5;
    logic [7:0] code7, code5;
    logic       tc7, tc5;

    always #5 clk = ~clk;

    code_counter_encoder #(.WIDTH(3)) dut7 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .mode(mode), .count(count7), .code_out(code7), .tc(tc7));

    code_counter_encoder #(.WIDTH(3), .MAX_COUNT(5)) dut5 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .mode(mode), .count(count5), .code_out(code5), .tc(tc5));

    typedef struct {
        int c5, c7, k5, k7, t5, t7;
        bit gray;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   m5 = 0, m7 = 0;
    logic [7:0] prev7 = '0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    endtask

    function automatic int enc(input int k, input int md);
        case (md)
            0:       return k;
            1:       return k ^ (k >> 1);
            2:       return 1 << k;
            default: return (1 << k) - 1;
        endcase
    endfunction

    function automatic void adv(input int c, input int mx, input bit ld, input int lv,
                                input bit e, input bit u, output int n, output int t);
        t = 0;
        n = c;
        if (ld) n = (lv > mx) ? mx : lv;
        else if (e && u) begin
            if (c == mx) begin n = 0; t = 1; end else n = c + 1;
        end else if (e) begin
            if (c == 0) begin n = mx; t = 1; end else n = c - 1;
        end
    endfunction

    task automatic step(input bit e, input bit u, input bit ld, input int lv,
                        input int md, input bit g);
        int n, t5, t7;
        @(negedge clk);
        en = e; up = u; load = ld; load_val = 3'(lv); mode = 2'(md);
        @(posedge clk);
        adv(m5, 5, ld, lv, e, u, n, t5); m5 = n;
        adv(m7, 7, ld, lv, e, u, n, t7); m7 = n;
        sb.push_back('{m5, m7, enc(m5, md), enc(m7, md), t5, t7, g});
    endtask

    // Asynchronous reset asserted mid-cycle; optional check of the instant
    // response against the code expected for the mode already in effect.
    task automatic do_reset(input int md, input bit pre_chk, input int pre_code);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        if (pre_chk) begin
            chk("rst_async_count7", int'(count7), 0);
            chk("rst_async_count5", int'(count5), 0);
            chk("rst_async_code7", int'(code7), pre_code);
            chk("rst_async_code5", int'(code5), pre_code);
            chk("rst_async_tc7", int'(tc7), 0);
            chk("rst_async_tc5", int'(tc5), 0);
        end
        en = 1'b0; load = 1'b0; mode = 2'(md);
        @(posedge clk);
        #1;
        chk("rst_edge_code7", int'(code7), enc(0, md));
        chk("rst_edge_code5", int'(code5), enc(0, md));
        chk("rst_edge_count7", int'(count7), 0);
        chk("rst_edge_tc5", int'(tc5), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        m5 = 0;
        m7 = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) prev7 = code7;
        else if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("count5", int'(count5), e.c5);
            chk("count7", int'(count7), e.c7);
            chk("code5", int'(code5), e.k5);
            chk("code7", int'(code7), e.k7);
            chk("tc5", int'(tc5), e.t5);
            chk("tc7", int'(tc7), e.t7);
            if (e.gray) chk("gray_1bit", $countones(code7 ^ prev7), 1);
            prev7 = code7;
        end
    end

    initial begin
        #1;
        chk("init_count7", int'(count7), 0);
        chk("init_tc7", int'(tc7), 0);
        do_reset(0, 1'b0, 0);

        // Reset mid-count with one-hot mode
        step(0, 0, 1, 5, 2, 0);
        do_reset(1, 1'b1, 1);

        // Gray up-count through the wrap
        repeat (9) step(1, 1, 0, 0, 1, 1);

        // Down wrap from 1
        step(0, 0, 1, 1, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0);

        // Load priority and clamp, then wrap from the clamped value
        step(1, 1, 1, 7, 0, 0);
        step(1, 1, 0, 0, 0, 0);

        // Mode switch with count held
        step(0, 0, 1, 3, 0, 0);
        step(0, 0, 0, 0, 3, 0);
        step(0, 0, 0, 0, 2, 0);

        // Hold
        step(0, 0, 1, 6, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) do_reset(int'($urandom_range(0, 3)), 1'b0, 0);
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 3)), 0);
        end

        @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
